// File: rtl/fpu_addsub_issue.sv
// Issue/writeback stage around the external fadd/fsub units: a request FIFO feeds the head
// operands to both units, and the selected result is captured into a valid/ready output register.
module fpu_addsub_issue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_op,
   input  logic [31:0]               req_x1,
   input  logic [31:0]               req_x2,
   input  logic [TAG_W-1:0]          req_tag,
   output logic [31:0]               fa_x1,
   output logic [31:0]               fa_x2,
   input  logic [31:0]               add_y,
   input  logic                      add_ovf,
   input  logic [31:0]               sub_y,
   input  logic                      sub_ovf,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [31:0]               res_y,
   output logic                      res_ovf,
   output logic [TAG_W-1:0]          res_tag,
   input  logic                      ovf_clr,
   output logic                      ovf_sticky,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ZERO_CNT = CW'(1'b0);

   logic             op_mem_r  [DEPTH];
   logic [31:0]      x1_mem_r  [DEPTH];
   logic [31:0]      x2_mem_r  [DEPTH];
   logic [TAG_W-1:0] tag_mem_r [DEPTH];

   logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]    count_r, count_next_s;
   logic             ready_r, res_valid_r, res_ovf_r, sticky_r;
   logic [31:0]      res_y_r;
   logic [TAG_W-1:0] res_tag_r;
   logic             push_s, load_s, sel_ovf_s;
   logic [31:0]      sel_y_s;

   // Handshake decode, result selection by head op, and next occupancy.
   always_comb begin
      push_s    = req_valid && ready_r;
      load_s    = (count_r != ZERO_CNT) && (!res_valid_r || res_ready);
      sel_y_s   = add_y;
      sel_ovf_s = add_ovf;
      if (op_mem_r[rd_ptr_r]) begin
         sel_y_s   = sub_y;
         sel_ovf_s = sub_ovf;
      end else begin
         sel_y_s   = add_y;
         sel_ovf_s = add_ovf;
      end
      case ({push_s, load_s})
         2'b10:   count_next_s = count_r + CW'(1'b1);
         2'b01:   count_next_s = count_r - CW'(1'b1);
         default: count_next_s = count_r;
      endcase
   end

   // FIFO storage; written at the tail on every accepted request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            op_mem_r[i]  <= 1'b0;
            x1_mem_r[i]  <= 32'h0000_0000;
            x2_mem_r[i]  <= 32'h0000_0000;
            tag_mem_r[i] <= {TAG_W{1'b0}};
         end
      end else if (push_s) begin
         op_mem_r[wr_ptr_r]  <= req_op;
         x1_mem_r[wr_ptr_r]  <= req_x1;
         x2_mem_r[wr_ptr_r]  <= req_x2;
         tag_mem_r[wr_ptr_r] <= req_tag;
      end
   end

   // Pointers, occupancy and the registered ready (so ready never depends on res_ready combinationally).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= ZERO_CNT;
         ready_r  <= 1'b1;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         if (load_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         count_r <= count_next_s;
         ready_r <= (count_next_s != FULL_CNT);
      end
   end

   // Output register: load from the head, otherwise drop valid once consumed; data holds until next load.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_valid_r <= 1'b0;
         res_y_r     <= 32'h0000_0000;
         res_ovf_r   <= 1'b0;
         res_tag_r   <= {TAG_W{1'b0}};
      end else if (load_s) begin
         res_valid_r <= 1'b1;
         res_y_r     <= sel_y_s;
         res_ovf_r   <= sel_ovf_s;
         res_tag_r   <= tag_mem_r[rd_ptr_r];
      end else if (res_ready && res_valid_r) begin
         res_valid_r <= 1'b0;
      end
   end

   // Sticky overflow: a new overflowing load beats a simultaneous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sticky_r <= 1'b0;
      end else if (load_s && sel_ovf_s) begin
         sticky_r <= 1'b1;
      end else if (ovf_clr) begin
         sticky_r <= 1'b0;
      end
   end

   assign req_ready  = ready_r;
   assign fa_x1      = x1_mem_r[rd_ptr_r];
   assign fa_x2      = x2_mem_r[rd_ptr_r];
   assign res_valid  = res_valid_r;
   assign res_y      = res_y_r;
   assign res_ovf    = res_ovf_r;
   assign res_tag    = res_tag_r;
   assign ovf_sticky = sticky_r;
   assign count      = count_r;
endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Scoreboard bench for fpu_addsub_issue; stand-in fadd/fsub units are driven from the DUT's head operands.
module tb_fpu_addsub_issue;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic rstn, req_valid, req_ready, req_op;
   logic [31:0] req_x1, req_x2, fa_x1, fa_x2, add_y, sub_y, res_y;
   logic [TAG_W-1:0] req_tag, res_tag;
   logic add_ovf, sub_ovf, res_valid, res_ready, res_ovf, ovf_clr, ovf_sticky;
   logic [$clog2(DEPTH):0] count;

   typedef struct packed {
      logic [31:0]      y;
      logic             ovf;
      logic [TAG_W-1:0] tag;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int n_in = 0;
   int n_out = 0;
   logic rand_rr = 1'b0;

   always #5 clk = ~clk;

   // Stand-in units: exact IEEE results for the directed vectors, arbitrary deterministic values otherwise.
   function automatic logic [32:0] unit_add(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
      else if (a == 32'h3F80_0000 && b == 32'hBF80_0000) return {1'b0, 32'h0000_0000};
      else if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {1'b1, 32'h7F80_0000};
      else return {a[0] & b[0], a + b};
   endfunction

   function automatic logic [32:0] unit_sub(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4040_0000 && b == 32'h3F80_0000) return {1'b0, 32'h4000_0000};
      else return {a[1] ^ b[1], a - b};
   endfunction

   assign {add_ovf, add_y} = unit_add(fa_x1, fa_x2);
   assign {sub_ovf, sub_y} = unit_sub(fa_x1, fa_x2);

   fpu_addsub_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag), .fa_x1(fa_x1), .fa_x2(fa_x2),
      .add_y(add_y), .add_ovf(add_ovf), .sub_y(sub_y), .sub_ovf(sub_ovf),
      .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_ovf(res_ovf),
      .res_tag(res_tag), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: compare the held result against the scoreboard head, then record accepted requests.
   always @(negedge clk) begin
      if (rstn) begin
         chk("count_le_depth", 32'(count <= DEPTH), 32'd1);
         chk("ready_vs_count", 32'(req_ready), 32'(count != DEPTH));
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_result", 32'(res_tag), 32'hFFFF_FFFF);
            end else begin
               chk("res_y", res_y, exp_q[0].y);
               chk("res_ovf", 32'(res_ovf), 32'(exp_q[0].ovf));
               chk("res_tag", 32'(res_tag), 32'(exp_q[0].tag));
               if (res_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (req_valid && req_ready) begin
            logic [32:0] r;
            r = req_op ? unit_sub(req_x1, req_x2) : unit_add(req_x1, req_x2);
            exp_q.push_back('{y: r[31:0], ovf: r[32], tag: req_tag});
            n_in++;
         end
      end
   end

   // Random consumer back-pressure while enabled.
   always @(posedge clk) begin
      if (rand_rr) begin
         #2 res_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset(input string p);
      chk({p, "_valid"}, 32'(res_valid), 32'd0);
      chk({p, "_y"}, res_y, 32'd0);
      chk({p, "_ovf"}, 32'(res_ovf), 32'd0);
      chk({p, "_tag"}, 32'(res_tag), 32'd0);
      chk({p, "_sticky"}, 32'(ovf_sticky), 32'd0);
      chk({p, "_count"}, 32'(count), 32'd0);
      chk({p, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   // Called and returns at posedge+2; holds the request until accepted (bounded).
   task automatic send(input logic op, input logic [31:0] x1, input logic [31:0] x2, input logic [TAG_W-1:0] tag);
      logic acc;
      acc = 1'b0;
      req_valid = 1'b1; req_op = op; req_x1 = x1; req_x2 = x2; req_tag = tag;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk) acc = req_ready;
         @(posedge clk); #2;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && (exp_q.size() != 0 || res_valid); i++) begin
         @(posedge clk); #2;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n0;
      rstn = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_x1 = 32'd0; req_x2 = 32'd0;
      req_tag = '0; res_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      @(posedge clk); #2 rstn = 1'b1;

      // Minimum latency: accepted at edge k, result visible after edge k+1.
      res_ready = 1'b1;
      @(posedge clk); #2;
      req_valid = 1'b1; req_op = 1'b0; req_x1 = 32'h3F80_0000; req_x2 = 32'h4000_0000; req_tag = 5'd3;
      @(posedge clk); #2 req_valid = 1'b0;
      @(negedge clk) chk("lat_edge_k", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("lat_edge_k1", 32'(res_valid), 32'd1);
      chk("lat_y", res_y, 32'h4040_0000);
      chk("lat_tag", 32'(res_tag), 32'd3);
      @(posedge clk); #2;
      wait_drain();

      send(1'b1, 32'h4040_0000, 32'h3F80_0000, 5'd4);
      send(1'b0, 32'h3F80_0000, 32'hBF80_0000, 5'd5);
      wait_drain();

      // Overflow sets sticky; clear pulse drops it.
      send(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd6);
      wait_drain();
      chk("sticky_set", 32'(ovf_sticky), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk); #2 ovf_clr = 1'b0;
      chk("sticky_clr", 32'(ovf_sticky), 32'd0);

      // Clear on the same edge as an overflowing load: set wins.
      send(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd7);
      ovf_clr = 1'b1;
      @(posedge clk); #2 ovf_clr = 1'b0;
      chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
      wait_drain();

      // Back-pressure: six back-to-back pushes, only five fit.
      res_ready = 1'b0;
      n0 = n_in;
      for (int t = 0; t < 6; t++) begin
         req_valid = 1'b1; req_op = 1'($urandom_range(0, 1));
         req_x1 = $urandom; req_x2 = $urandom; req_tag = 5'(t);
         @(posedge clk); #2;
      end
      req_valid = 1'b0;
      chk("bp_accepted", 32'(n_in - n0), 32'd5);
      chk("bp_count_full", 32'(count), 32'd4);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_hold_tag", 32'(res_tag), 32'd0);
      res_ready = 1'b1;
      n0 = n_in;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_op = 1'($urandom_range(0, 1));
         req_x1 = $urandom; req_x2 = $urandom; req_tag = 5'(10 + i);
         @(negedge clk) chk("drain_rate", 32'(res_valid), 32'd1);
         @(posedge clk); #2;
      end
      req_valid = 1'b0;
      chk("accept_during_drain", 32'(n_in - n0 > 0), 32'd1);
      wait_drain();

      // Wrap: 3*DEPTH requests under random back-pressure.
      n0 = n_out;
      rand_rr = 1'b1;
      for (int k = 0; k < 3 * DEPTH; k++)
         send(1'($urandom_range(0, 1)), $urandom, $urandom, 5'(16 + k));
      rand_rr = 1'b0;
      @(posedge clk); #2 res_ready = 1'b1;
      wait_drain();
      chk("wrap_all_out", 32'(n_out - n0), 32'(3 * DEPTH));

      // Asynchronous reset with a held result and three queued entries.
      res_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send(1'b0, $urandom, $urandom, 5'(k));
      @(negedge clk);
      chk("pre_rst_count", 32'(count), 32'd3);
      chk("pre_rst_valid", 32'(res_valid), 32'd1);
      #1 rstn = 1'b0;
      #1 chk_reset("async_rst");
      exp_q.delete();
      @(posedge clk); #2 rstn = 1'b1;
      res_ready = 1'b1;
      n0 = n_out;
      send(1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd9);
      wait_drain();
      chk("post_rst_one_out", 32'(n_out - n0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
